matmul_sequencer: RTL and testbench

- Controller that sequences one shared multiply-accumulate datapath over the three nested loops of C = A x B, for square matrices of runtime size n (1..MAX_N).
- Reads A and B from synchronous single-port operand RAMs and writes each finished C element to a result RAM.
- Sits between the system control FSM (which loads A/B over UART, then pulses start) and the result-transmit path (which waits for done).

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/matmul_mac.sv | 57 +++++
 rtl/matmul_sequencer.sv | 169 ++++++++++++++++
 tb/tb_matmul_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and helpers for the matmul sequencer
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Accumulator width: full product plus enough headroom for max_n additions.
  function automatic int acc_width(input int data_w, input int max_n);
    return 2 * data_w + $clog2(max_n);
  endfunction

  // A size is legal when it is in 1..max_n.
  function automatic logic size_legal(input logic [3:0] n, input int max_n);
    return (n != 4'd0) && (int'(n) <= max_n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - signed multiply-accumulate with OUT_W reduction (MATMUL_SAT_EN selects saturation)
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 4,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic                     first_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic        [OUT_W-1:0]  acc_out_o
`ifdef MATMUL_SAT_EN
  , output logic                   sat_o
`endif
);

  localparam int ACC_W = acc_width(DATA_W, MAX_N);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q;

  assign prod = a_i * b_i;

  // First product of an element loads the accumulator, later ones add to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (valid_i) begin
      acc_q <= first_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
    end
  end

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (OUT_W - 1)));

  // Clip the accumulator into the signed OUT_W range and flag any clipping.
  always_comb begin
    sat_o     = 1'b0;
    acc_out_o = acc_q[OUT_W-1:0];
    if (acc_q > SAT_HI) begin
      sat_o     = 1'b1;
      acc_out_o = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (acc_q < SAT_LO) begin
      sat_o     = 1'b1;
      acc_out_o = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end
`else
  assign acc_out_o = acc_q[OUT_W-1:0];
`endif

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - sequences one MAC over C = A x B (MATMUL_SAT_EN adds saturation and sat_flag)
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int MAX_N  = 4,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic        [3:0]        size_n,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     rd_en,
  output logic        [ADDR_W-1:0] a_addr,
  output logic        [ADDR_W-1:0] b_addr,
  input  logic signed [DATA_W-1:0] a_rdata,
  input  logic signed [DATA_W-1:0] b_rdata,
  output logic                     c_we,
  output logic        [ADDR_W-1:0] c_addr,
  output logic        [OUT_W-1:0]  c_wdata
`ifdef MATMUL_SAT_EN
  , output logic                   sat_flag
`endif
);

  state_e            state_q, state_d;
  logic [3:0]        n_q, n_d;
  logic [3:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;  // i*n
  logic [ADDR_W-1:0] k_base_q, k_base_d;      // k*n
  logic              err_q, err_d;
  logic              valid_q, first_q;
  logic [ADDR_W-1:0] n_ext;
`ifdef MATMUL_SAT_EN
  logic              sat_flag_q, sat_flag_d;
  logic              mac_sat;
`endif

  assign n_ext = ADDR_W'(n_q);

  // State, counters, address bases and the one-cycle read-data qualifiers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      row_base_q <= '0;
      k_base_q   <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
`ifdef MATMUL_SAT_EN
      sat_flag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      row_base_q <= row_base_d;
      k_base_q   <= k_base_d;
      err_q      <= err_d;
      valid_q    <= (state_q == ST_RUN);
      first_q    <= (state_q == ST_RUN) && (k_q == 4'd0);
`ifdef MATMUL_SAT_EN
      sat_flag_q <= sat_flag_d;
`endif
    end
  end

  // Next-state, loop counter stepping and strobes.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    row_base_d = row_base_q;
    k_base_d   = k_base_q;
    err_d      = 1'b0;
`ifdef MATMUL_SAT_EN
    sat_flag_d = sat_flag_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (size_legal(size_n, MAX_N)) begin
            n_d        = size_n;
            i_d        = '0;
            j_d        = '0;
            k_d        = '0;
            row_base_d = '0;
            k_base_d   = '0;
            state_d    = ST_RUN;
`ifdef MATMUL_SAT_EN
            sat_flag_d = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (k_q == n_q - 4'd1) begin
          k_d      = '0;
          k_base_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          k_d      = k_q + 4'd1;
          k_base_d = k_base_q + n_ext;
        end
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
`ifdef MATMUL_SAT_EN
        if (mac_sat) sat_flag_d = 1'b1;
`endif
        state_d = ST_RUN;
        if (j_q == n_q - 4'd1) begin
          j_d        = '0;
          i_d        = i_q + 4'd1;
          row_base_d = row_base_q + n_ext;
          if (i_q == n_q - 4'd1) state_d = ST_DONE;
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign err    = err_q;
  assign rd_en  = (state_q == ST_RUN);
  assign c_we   = (state_q == ST_WRITE);
  assign a_addr = row_base_q + ADDR_W'(k_q);
  assign b_addr = k_base_q + ADDR_W'(j_q);
  assign c_addr = row_base_q + ADDR_W'(j_q);
`ifdef MATMUL_SAT_EN
  assign sat_flag = sat_flag_q;
`endif

  matmul_mac #(
    .DATA_W(DATA_W),
    .MAX_N (MAX_N),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_q),
    .first_i  (first_q),
    .a_i      (a_rdata),
    .b_i      (b_rdata),
    .acc_out_o(c_wdata)
`ifdef MATMUL_SAT_EN
    , .sat_o  (mac_sat)
`endif
  );

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - directed self-checking bench for matmul_sequencer
module tb_matmul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  size_n = 4'd0;
  logic        busy, done, err, rd_en, c_we;
  logic [3:0]  a_addr, b_addr, c_addr;
  logic [7:0]  a_rdata = 8'd0;
  logic [7:0]  b_rdata = 8'd0;
  logic [15:0] c_wdata;
`ifdef MATMUL_SAT_EN
  logic        sat_flag;
`endif

  logic [7:0]  a_mem [16];
  logic [7:0]  b_mem [16];
  logic [15:0] exp_c [16];
  logic [3:0]  wr_addr [$];
  logic [15:0] wr_data [$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  localparam int A3 [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  localparam int B3 [9] = '{1, 0, -1, 2, 1, 0, 0, -2, 3};
  localparam int C3 [9] = '{5, -4, 8, 14, -7, 14, 23, -10, 20};

  matmul_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .size_n (size_n),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .rd_en  (rd_en),
    .a_addr (a_addr),
    .b_addr (b_addr),
    .a_rdata(a_rdata),
    .b_rdata(b_rdata),
    .c_we   (c_we),
    .c_addr (c_addr),
    .c_wdata(c_wdata)
`ifdef MATMUL_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port operand RAMs.
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[a_addr];
      b_rdata <= b_mem[b_addr];
    end
  end

  // Result RAM write log and pulse counters.
  always @(negedge clk) begin
    if (c_we === 1'b1) begin
      wr_addr.push_back(c_addr);
      wr_data.push_back(c_wdata);
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_mem();
    for (int e = 0; e < 16; e++) begin
      a_mem[e] = 8'd0;
      b_mem[e] = 8'd0;
      exp_c[e] = 16'd0;
    end
  endtask

  task automatic load3();
    clear_mem();
    for (int e = 0; e < 9; e++) begin
      a_mem[e] = 8'(A3[e]);
      b_mem[e] = 8'(B3[e]);
      exp_c[e] = 16'(C3[e]);
    end
  endtask

  task automatic run_mm(input string tag, input int n, input int exp_lat, input int restart_at);
    int   cyc;
    logic busy_ok;
    busy_ok = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    done_cnt = 0;
    err_cnt  = 0;
    start  = 1'b1;
    size_n = n[3:0];
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 400) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (restart_at > 0 && cyc == restart_at) begin
        start  = 1'b1;
        size_n = 4'd2;
      end else if (restart_at > 0 && cyc == restart_at + 1) begin
        start  = 1'b0;
        size_n = 4'd0;
      end
      @(negedge clk);
      cyc++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    check({tag, " done latency"}, cyc, exp_lat);
    check({tag, " busy throughout"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    check({tag, " done/busy after"}, {30'd0, done, busy}, 32'd0);
    @(negedge clk);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " no err"}, err_cnt, 0);
    check({tag, " write count"}, wr_addr.size(), n * n);
    for (int e = 0; e < n * n; e++) begin
      if (e < wr_addr.size()) begin
        check($sformatf("%s addr%0d", tag, e), {28'd0, wr_addr[e]}, e);
        check($sformatf("%s data%0d", tag, e), {16'd0, wr_data[e]}, {16'd0, exp_c[e]});
      end
    end
  endtask

  initial begin
    int cyc;
    clear_mem();

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset strobes", {27'd0, busy, done, err, rd_en, c_we}, 32'd0);
    check("reset addr/data", {a_addr, b_addr, c_addr, c_wdata}, 32'd0);

    // n=1: 3 * -4 = -12, done after 4 cycles
    clear_mem();
    a_mem[0] = 8'(3);
    b_mem[0] = 8'(-4);
    exp_c[0] = 16'(-12);
    run_mm("n1", 1, 4, 0);

    // n=2: A x identity = A
    clear_mem();
    a_mem[0] = 8'd1; a_mem[1] = 8'd2; a_mem[2] = 8'd3; a_mem[3] = 8'd4;
    b_mem[0] = 8'd1; b_mem[3] = 8'd1;
    exp_c[0] = 16'd1; exp_c[1] = 16'd2; exp_c[2] = 16'd3; exp_c[3] = 16'd4;
    run_mm("n2 ident", 2, 17, 0);

    // n=4: all 127 -> 64516 per element
    for (int e = 0; e < 16; e++) begin
      a_mem[e] = 8'd127;
      b_mem[e] = 8'd127;
`ifdef MATMUL_SAT_EN
      exp_c[e] = 16'h7FFF;
`else
      exp_c[e] = 16'hFC04;
`endif
    end
    run_mm("n4 max", 4, 97, 0);
`ifdef MATMUL_SAT_EN
    check("sat_flag set", {31'd0, sat_flag}, 32'd1);
`endif

    // Illegal sizes
    @(negedge clk);
    start = 1'b1; size_n = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("size0 err pulse", {31'd0, err}, 32'd1);
    check("size0 idle", {29'd0, busy, rd_en, c_we}, 32'd0);
    @(negedge clk);
    check("size0 err once", {28'd0, err, busy, rd_en, c_we}, 32'd0);
    start = 1'b1; size_n = 4'd5;
    @(negedge clk);
    start = 1'b0;
    check("size5 err pulse", {31'd0, err}, 32'd1);
    check("size5 idle", {29'd0, busy, rd_en, c_we}, 32'd0);
    @(negedge clk);
    check("size5 err once", {28'd0, err, busy, rd_en, c_we}, 32'd0);

    // n=3 with a second start (and new size) at cycle 10, which must be ignored
    load3();
    run_mm("n3 restart", 3, 46, 10);
`ifdef MATMUL_SAT_EN
    check("sat_flag cleared", {31'd0, sat_flag}, 32'd0);
`endif

    // n=3 with reset at cycle 20
    load3();
    @(negedge clk);
    start = 1'b1; size_n = 4'd3;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst strobes", {27'd0, busy, done, err, rd_en, c_we}, 32'd0);
    check("midrst addr/data", {a_addr, b_addr, c_addr, c_wdata}, 32'd0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst no done", done_cnt, 0);
    check("midrst idle", {31'd0, busy}, 32'd0);

    // Fresh n=2 after reset: [[1,2],[3,4]] x [[5,6],[7,8]]
    clear_mem();
    a_mem[0] = 8'd1; a_mem[1] = 8'd2; a_mem[2] = 8'd3; a_mem[3] = 8'd4;
    b_mem[0] = 8'd5; b_mem[1] = 8'd6; b_mem[2] = 8'd7; b_mem[3] = 8'd8;
    exp_c[0] = 16'd19; exp_c[1] = 16'd22; exp_c[2] = 16'd43; exp_c[3] = 16'd50;
    run_mm("n2 after rst", 2, 17, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
